led_panel_phy: RTL and testbench
================================

Name: led_panel_phy

Overview:
- HUB75-style physical-layer driver for a 64-column x 32-row RGB LED matrix panel, 1 bit per colour, driven as two halves scanned in parallel (rows r and r+16).
- Consumes a streamed pixel-pair interface from the pattern generator or frame buffer.
- Generates the panel bit clock, serial RGB data, latch, output-enable and row address.
- Sits between the pattern generator and the board pins; uses a single system clock.

Parameters:
- SYS_CLK_FREQ, 100_000_000: system clock frequency in Hz.
- NUM_ROW_PIXELS, 32: panel rows; must be even.
- NUM_COL_PIXELS, 64: panel columns.
- BCLK_FREQ, 25_000_000: panel bit clock frequency in Hz.
- SYS_CLK_FREQ/BCLK_FREQ must be an even integer >= 2. It defines the local constant CLK_DIV (default 4).
- ADDR_W = clog2(NUM_ROW_PIXELS/2). Default 4.

Ports:
- clk_in  in  1  system clock.
- n_reset_in  in  1  reset. Asynchronous assert, active-low.
- pix_valid_in  in  1  pixel pair available.
- pix_top_in  in  3  {R,G,B} for the upper-half pixel (row r).
- pix_bot_in  in  3  {R,G,B} for the lower-half pixel (row r+NUM_ROW_PIXELS/2).
- pix_ready_out  out  1  pixel pair accepted on this cycle when pix_valid_in is also high.
- rgb_top_out  out  3  panel R1,G1,B1.
- rgb_bot_out  out  3  panel R2,G2,B2.
- bclk_out  out  1  panel shift clock.
- latch_out  out  1  panel latch (STB), active-high.
- oe_n_out  out  1  panel output enable, active-low.
- addr_out  out  ADDR_W  panel row address A..D.
- frame_done_out  out  1  one-cycle pulse after the last row of a frame is latched.

Behaviour:
- Reset values: bclk_out=0, latch_out=0, oe_n_out=1 (blanked), addr_out=0, rgb outputs=0, pix_ready_out=0, frame_done_out=0.
- Reset deassertion is synchronised internally. The first state after reset is SHIFT, with column=0 and row=0.
- Pixel order: for row r = 0..NUM_ROW_PIXELS/2-1, columns 0..NUM_COL_PIXELS-1. After the last row, wrap to row 0.
- All outputs are registered. pix_ready_out is combinational from state only, never from pix_valid_in.
- State machine: SHIFT -> BLANK -> LATCH -> UNBLANK -> SHIFT.
- SHIFT, per column:
  - Phase LOW: bclk_out=0 and pix_ready_out=1 until a transfer (valid & ready). While pix_valid_in=0, hold bclk_out low indefinitely; the panel is unaffected.
  - On transfer, register pix_top_in/pix_bot_in onto the rgb outputs. pix_ready_out drops the next cycle.
  - Data stays low-phase for CLK_DIV/2 cycles after transfer (setup), then bclk_out=1 for CLK_DIV/2 cycles (panel samples on the rising edge).
  - Then the next column starts. One column takes exactly CLK_DIV cycles when valid is always high.
  - rgb outputs hold their value until the next transfer.
- After column NUM_COL_PIXELS-1 high phase completes: BLANK. oe_n_out=1 for CLK_DIV cycles, and addr_out is updated to the shifted row at BLANK entry.
- LATCH: latch_out=1 for CLK_DIV cycles, bclk_out=0.
- UNBLANK: latch_out=0 and oe_n_out=0, held for 1 cycle.
- Return to SHIFT for row+1. oe_n_out stays 0 during SHIFT, so the previous row is displayed while the next one shifts.
- After latching row NUM_ROW_PIXELS/2-1: frame_done_out pulses 1 cycle in UNBLANK, and row wraps to 0.
- The first row after reset stays blanked (oe_n=1) until its latch completes.
- Reset mid-row: all counters and outputs return to reset values immediately. The partial row is discarded and the stream restarts at row 0, column 0.

Decomposition:
- Shared package led_display_pkg holds:
  - typedef rgb_t (logic [2:0]);
  - the panel geometry constants (32, 64);
  - state enum phy_state_t.
- One natural sub-module: led_bclk_gen. It is the CLK_DIV/2 phase counter producing the tick and phase signals; it holds while a stall is requested.

Test Plan:
- Reset: hold n_reset_in=0 with random valid/data -> bclk_out=0, oe_n_out=1, latch_out=0, addr_out=0, rgb=0 throughout.
- Continuous stream, valid always 1, defaults -> bclk_out period 40 ns (2 high/2 low cycles). Exactly 64 rising edges per row. Row 0 latch pulse 40 ns wide; oe_n_out=1 around it for 80 ns total. addr_out=0 during the row-0 latch, 1 during the row-1 latch.
- Data check: column c of row r carries top=(r+c)%8 and bot=~top -> on every bclk rising edge, rgb_top_out/rgb_bot_out match the pixel for that column. The panel model reconstructs the frame exactly.
- Stall: drop pix_valid_in for 17 cycles at column 10 -> bclk_out stays low, outputs hold. No extra or lost rising edge; column 10 data correct after resume.
- Frame wrap: stream 16 rows x 64 pixels -> a single frame_done_out pulse after the row-15 latch. The next row latched uses addr_out=0.
- Mid-row reset at column 30 of row 5 -> outputs return to reset values within 1 cycle. After release, the first latch uses addr_out=0 with 64 fresh pixels.

Source files
------------

// File: rtl/led_display_pkg.sv
// rtl/led_display_pkg.sv - shared types, panel geometry and scan states for the LED panel driver
package led_display_pkg;

    typedef logic [2:0] rgb_t;

    localparam int PANEL_ROWS = 32;
    localparam int PANEL_COLS = 64;

    typedef enum logic [1:0] {
        ST_SHIFT   = 2'd0,
        ST_BLANK   = 2'd1,
        ST_LATCH   = 2'd2,
        ST_UNBLANK = 2'd3
    } phy_state_t;

endpackage

// File: rtl/led_bclk_gen.sv
// rtl/led_bclk_gen.sv - half-period phase counter pacing the panel bit clock and blank/latch timing
module led_bclk_gen #(
    parameter int HALF_DIV = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic en,
    input  logic stall,
    output logic phase,
    output logic slot_start,
    output logic half_end
);

    localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             advance;

    assign advance    = en && !stall;
    assign half_end   = advance && (cnt == CNT_LAST);
    assign slot_start = !phase && (cnt == '0);

    // Count out each half period and flip the phase; a stall freezes both.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (advance) begin
            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_panel_phy.sv
// rtl/led_panel_phy.sv - HUB75 panel driver: shifts pixel pairs, blanks, latches and scans rows
module led_panel_phy
    import led_display_pkg::*;
#(
    parameter int SYS_CLK_FREQ   = 100_000_000,
    parameter int NUM_ROW_PIXELS = PANEL_ROWS,
    parameter int NUM_COL_PIXELS = PANEL_COLS,
    parameter int BCLK_FREQ      = 25_000_000,
    localparam int ADDR_W        = $clog2(NUM_ROW_PIXELS / 2)
) (
    input  logic              clk_in,
    input  logic              n_reset_in,
    input  logic              pix_valid_in,
    input  rgb_t              pix_top_in,
    input  rgb_t              pix_bot_in,
    output logic              pix_ready_out,
    output rgb_t              rgb_top_out,
    output rgb_t              rgb_bot_out,
    output logic              bclk_out,
    output logic              latch_out,
    output logic              oe_n_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              frame_done_out
);

    localparam int CLK_DIV       = SYS_CLK_FREQ / BCLK_FREQ;
    localparam int HALF_DIV      = CLK_DIV / 2;
    localparam int NUM_SCAN_ROWS = NUM_ROW_PIXELS / 2;
    localparam int COL_W         = (NUM_COL_PIXELS > 1) ? $clog2(NUM_COL_PIXELS) : 1;

    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(NUM_COL_PIXELS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_SCAN_ROWS - 1);

    logic rst_meta;
    logic rst_n_int;
    logic run;

    phy_state_t        state;
    phy_state_t        state_nxt;
    logic [COL_W-1:0]  col;
    logic [COL_W-1:0]  col_nxt;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] row_nxt;

    logic phase;
    logic slot_start;
    logic half_end;
    logic period_end;
    logic gen_en;
    logic stall;
    logic xfer;

    // Assert reset immediately, release it only after two clean clock edges.
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            rst_meta  <= 1'b0;
            rst_n_int <= 1'b0;
        end else begin
            rst_meta  <= 1'b1;
            rst_n_int <= rst_meta;
        end
    end

    // Keep the stream closed for the first cycle out of reset.
    always_ff @(posedge clk_in or negedge rst_n_int) begin
        if (!rst_n_int) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Ready only in the first low slot of a column, so it never depends on valid.
    assign pix_ready_out = run && (state == ST_SHIFT) && slot_start;
    assign xfer          = pix_valid_in && pix_ready_out;
    assign stall         = pix_ready_out && !pix_valid_in;
    assign gen_en        = run && (state != ST_UNBLANK);
    assign period_end    = half_end && phase;

    led_bclk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_bclk_gen (
        .clk_in     (clk_in),
        .rst_n      (rst_n_int),
        .en         (gen_en),
        .stall      (stall),
        .phase      (phase),
        .slot_start (slot_start),
        .half_end   (half_end)
    );

    // Scan sequencing: shift a full row, blank, latch, unblank, then the next row.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        case (state)
            ST_SHIFT: begin
                if (period_end) begin
                    if (col == LAST_COL) begin
                        col_nxt   = '0;
                        state_nxt = ST_BLANK;
                    end else begin
                        col_nxt = col + COL_W'(1);
                    end
                end
            end
            ST_BLANK: begin
                if (period_end) begin
                    state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (period_end) begin
                    state_nxt = ST_UNBLANK;
                end
            end
            ST_UNBLANK: begin
                state_nxt = ST_SHIFT;
                row_nxt   = (row == LAST_ROW) ? '0 : row + ADDR_W'(1);
            end
            default: begin
                state_nxt = ST_SHIFT;
            end
        endcase
    end

    // Scan position registers.
    always_ff @(posedge clk_in or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state <= ST_SHIFT;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
        end
    end

    // Panel pins, all registered; bclk trails the phase by one cycle so data leads the rising edge.
    always_ff @(posedge clk_in or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rgb_top_out    <= '0;
            rgb_bot_out    <= '0;
            bclk_out       <= 1'b0;
            latch_out      <= 1'b0;
            oe_n_out       <= 1'b1;
            addr_out       <= '0;
            frame_done_out <= 1'b0;
        end else begin
            bclk_out       <= (state == ST_SHIFT) && phase;
            latch_out      <= (state_nxt == ST_LATCH);
            frame_done_out <= (state == ST_LATCH) && (state_nxt == ST_UNBLANK) && (row == LAST_ROW);
            if (xfer) begin
                rgb_top_out <= pix_top_in;
                rgb_bot_out <= pix_bot_in;
            end
            if ((state == ST_SHIFT) && (state_nxt == ST_BLANK)) begin
                addr_out <= row;
                oe_n_out <= 1'b1;
            end else if ((state == ST_LATCH) && (state_nxt == ST_UNBLANK)) begin
                oe_n_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_panel_phy.sv
// tb/tb_led_panel_phy.sv - randomized scoreboard bench for the HUB75 panel driver
`timescale 1ns/1ps
module tb_led_panel_phy;
    import led_display_pkg::*;

    localparam int ROWS = 16;
    localparam int COLS = 64;
    localparam int VW   = COLS * 6;

    logic       clk_in       = 1'b0;
    logic       n_reset_in   = 1'b1;
    logic       pix_valid_in = 1'b0;
    rgb_t       pix_top_in   = '0;
    rgb_t       pix_bot_in   = '0;
    logic       pix_ready_out;
    rgb_t       rgb_top_out;
    rgb_t       rgb_bot_out;
    logic       bclk_out;
    logic       latch_out;
    logic       oe_n_out;
    logic [3:0] addr_out;
    logic       frame_done_out;

    always #5 clk_in = ~clk_in;

    led_panel_phy dut (
        .clk_in         (clk_in),
        .n_reset_in     (n_reset_in),
        .pix_valid_in   (pix_valid_in),
        .pix_top_in     (pix_top_in),
        .pix_bot_in     (pix_bot_in),
        .pix_ready_out  (pix_ready_out),
        .rgb_top_out    (rgb_top_out),
        .rgb_bot_out    (rgb_bot_out),
        .bclk_out       (bclk_out),
        .latch_out      (latch_out),
        .oe_n_out       (oe_n_out),
        .addr_out       (addr_out),
        .frame_done_out (frame_done_out)
    );

    int checks   = 0;
    int failures = 0;

    logic [5:0]    pix_q[$];
    logic [VW-1:0] row_q[$];
    int            pushed     = 0;
    int            rises      = 0;
    int            exp_frames = 0;
    int            obs_frames = 0;

    int            drv_row = 0;
    int            drv_col = 0;
    logic [VW-1:0] drv_vec = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_row(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        n_reset_in = 1'b0;
        pix_q.delete();
        row_q.delete();
        pushed  = 0;
        drv_row = 0;
        drv_col = 0;
        drv_vec = '0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_in);
            pix_valid_in = 1'($urandom);
            pix_top_in   = 3'($urandom);
            pix_bot_in   = 3'($urandom);
        end
        n_reset_in   = 1'b1;
        pix_valid_in = 1'b0;
    endtask

    task automatic send_pixel(input rgb_t top, input rgb_t bot, input int valid_pct);
        int  t;
        bit  done;
        t    = 0;
        done = 1'b0;
        while (!done && t < 200) begin
            @(negedge clk_in);
            pix_top_in   = top;
            pix_bot_in   = bot;
            pix_valid_in = (int'($urandom_range(0, 99)) < valid_pct);
            if (pix_valid_in && pix_ready_out) done = 1'b1;
            t++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no handshake want one within 200 cycles");
            return;
        end
        pix_q.push_back({top, bot});
        pushed++;
        drv_vec = {drv_vec[VW-7:0], top, bot};
        if (drv_col == COLS - 1) begin
            row_q.push_back(drv_vec);
            drv_col = 0;
            drv_row = (drv_row + 1) % ROWS;
        end else begin
            drv_col++;
        end
    endtask

    task automatic send_pattern(input int ncols, input int stall_col);
        rgb_t top;
        rgb_t prev_top;
        for (int c = 0; c < ncols; c++) begin
            top = 3'((drv_row + drv_col) % 8);
            if (c == stall_col) begin
                prev_top = 3'((drv_row + drv_col - 1) % 8);
                for (int i = 0; i < 17; i++) begin
                    @(negedge clk_in);
                    pix_valid_in = 1'b0;
                    pix_top_in   = 3'($urandom);
                    pix_bot_in   = 3'($urandom);
                end
                chk("stall_no_extra_edge", rises, pushed);
                chk("stall_bclk_low", longint'(bclk_out), 0);
                chk("stall_rgb_hold", longint'(rgb_top_out), longint'(prev_top));
                chk("stall_ready", longint'(pix_ready_out), 1);
            end
            send_pixel(top, ~top, 100);
        end
    endtask

    // Monitor: panel model reconstructs rows from bclk edges and checks latch, blank and frame timing.
    initial begin
        logic          pb;
        logic          pl;
        logic          po;
        logic          pf;
        int            hi_len;
        int            lat_len;
        int            oe_len;
        int            latch_idx;
        int            last_row;
        int            row_rises;
        bit            seen_unblank;
        logic [VW-1:0] sr;
        logic [5:0]    e;
        pb = 1'b0; pl = 1'b0; po = 1'b1; pf = 1'b0;
        hi_len = 0; lat_len = 0; oe_len = 0; latch_idx = 0; last_row = 0; row_rises = 0;
        seen_unblank = 1'b0;
        sr = '0;
        @(negedge n_reset_in);
        forever begin
            @(posedge clk_in);
            #2;
            if (!n_reset_in) begin
                chk("reset_outputs",
                    longint'({bclk_out, latch_out, oe_n_out, addr_out, rgb_top_out, rgb_bot_out,
                              pix_ready_out, frame_done_out}),
                    longint'({1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 3'd0, 1'b0, 1'b0}));
                pb = 1'b0; pl = 1'b0; po = 1'b1; pf = 1'b0;
                hi_len = 0; lat_len = 0; oe_len = 0; latch_idx = 0; row_rises = 0;
                seen_unblank = 1'b0;
                sr = '0;
                rises = 0;
                continue;
            end
            if (bclk_out && !pb) begin
                rises++;
                row_rises++;
                sr = {sr[VW-7:0], rgb_top_out, rgb_bot_out};
                if (pix_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bclk_extra_edge: got rising edge want none (no pixel pending)");
                end else begin
                    e = pix_q.pop_front();
                    chk("pixel_data", longint'({rgb_top_out, rgb_bot_out}), longint'(e));
                end
            end
            if (bclk_out) begin
                hi_len++;
            end else if (pb) begin
                chk("bclk_high_width", hi_len, 2);
                hi_len = 0;
            end
            if (latch_out && !pl) begin
                chk("latch_addr", longint'(addr_out), latch_idx % ROWS);
                chk("row_rises", row_rises, COLS);
                chk("latch_oe_blank", longint'(oe_n_out), 1);
                if (row_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL latch_extra: got latch want none (no full row sent)");
                end else begin
                    chk_row("panel_row", sr, row_q.pop_front());
                end
                last_row = latch_idx % ROWS;
                if (last_row == ROWS - 1) exp_frames++;
                latch_idx++;
                row_rises = 0;
            end
            if (latch_out) begin
                lat_len++;
            end else if (pl) begin
                chk("latch_width", lat_len, 4);
                lat_len = 0;
            end
            if (oe_n_out) begin
                oe_len++;
            end else begin
                if (po) begin
                    if (seen_unblank) chk("oe_blank_width", oe_len, 8);
                    seen_unblank = 1'b1;
                end
                oe_len = 0;
            end
            if (frame_done_out) begin
                obs_frames++;
                chk("frame_done_row", last_row, ROWS - 1);
                chk("frame_done_single", longint'(pf), 0);
            end
            pb = bclk_out;
            pl = latch_out;
            po = oe_n_out;
            pf = frame_done_out;
        end
    end

    // Stimulus: reset, continuous rows with a stall, mid-row reset, full frame wrap, random traffic.
    initial begin
        int budget;
        #1;
        do_reset(20);
        repeat (3) @(negedge clk_in);
        for (int r = 0; r < 5; r++) send_pattern(COLS, (r == 1) ? 10 : -1);
        send_pattern(30, -1);
        @(negedge clk_in);
        do_reset(6);
        repeat (2) @(negedge clk_in);
        for (int r = 0; r < ROWS + 2; r++) send_pattern(COLS, -1);
        for (int i = 0; i < 3 * COLS; i++) send_pixel(3'($urandom), 3'($urandom), 70);
        @(negedge clk_in);
        pix_valid_in = 1'b0;
        budget = 0;
        while ((row_q.size() != 0 || pix_q.size() != 0) && budget < 3000) begin
            @(negedge clk_in);
            budget++;
        end
        if (budget >= 3000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d rows pending want 0", row_q.size());
        end
        repeat (20) @(negedge clk_in);
        chk("frame_done_count", obs_frames, exp_frames);
        chk("total_edges", rises, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #300_000;
        checks++;
        failures++;
        $display("FAIL watchdog: got no completion want completion within 300 us");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
